// File: rtl/matmul_output_writer_pkg.sv
// Shared constants and types for the matmul output-writer slice.
package matmul_pkg;

  localparam int DWIDTH    = 16;
  localparam int MAT       = 4;
  localparam int AWIDTH    = 7;
  localparam int MEM_WIDTH = 64;

  // Element bit pattern; the writer never interprets it numerically.
  typedef logic [DWIDTH-1:0] fp16_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/matmul_output_writer_if.sv
// Ready-gated write port into the matrix C RAM.
interface matmul_output_writer_if #(
  parameter int AW = matmul_pkg::AWIDTH,
  parameter int MW = matmul_pkg::MEM_WIDTH
);

  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [MW-1:0] data_c;
  logic          mem_ready;

  modport master (output we_c, output addr_c, output data_c, input mem_ready);
  modport slave  (input we_c, input addr_c, input data_c, output mem_ready);

endinterface

// File: rtl/matmul_output_writer_row_mux.sv
// Selects one row of the result snapshot and packs it into a RAM word,
// column 0 in the least significant element.
module matmul_row_mux #(
  parameter int DWIDTH = matmul_pkg::DWIDTH,
  parameter int MAT    = matmul_pkg::MAT,
  parameter int ROWB   = 2
) (
  input  logic [MAT*MAT*DWIDTH-1:0] mat,
  input  logic [ROWB-1:0]           row,
  output logic [MAT*DWIDTH-1:0]     word
);
  import matmul_pkg::*;

  // Row i of the flat matrix is contiguous, so the element order carries over.
  always_comb begin
    word = '0;
    for (int j = 0; j < MAT; j++) begin
      word[j*DWIDTH +: DWIDTH] = mat[(int'(row)*MAT + j)*DWIDTH +: DWIDTH];
    end
  end

endmodule

// File: rtl/matmul_output_writer.sv
// Snapshots the systolic array results on done and drains them row by row
// into the matrix C RAM through a ready-gated write port.
//
// state    | meaning
// S_IDLE   | no job held; a done pulse loads the snapshot
// S_WRITE  | we_c high, row `row` presented until mem_ready accepts it
// S_FINISH | writes_done pulse, one cycle, new jobs still refused
module matmul_output_writer #(
  parameter int DWIDTH    = matmul_pkg::DWIDTH,
  parameter int MAT       = matmul_pkg::MAT,
  parameter int AWIDTH    = matmul_pkg::AWIDTH,
  parameter int MEM_WIDTH = matmul_pkg::MEM_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done_mat_mul,
  input  logic [MAT*MAT*DWIDTH-1:0] c_flat,
  input  logic [AWIDTH-1:0]         c_loc,
  matmul_output_writer_if.master    ram,
  output logic                      busy,
  output logic                      writes_done,
  output logic                      overrun
);
  import matmul_pkg::*;

  localparam int ROW_W = MAT * DWIDTH;
  localparam int MAT_W = MAT * ROW_W;
  localparam int ROWB  = (MAT > 1) ? $clog2(MAT) : 1;
  localparam logic [ROWB-1:0] LAST_ROW = ROWB'(MAT - 1);

  state_t                 state, state_nxt;
  logic [ROWB-1:0]        row, row_nxt;
  logic [AWIDTH-1:0]      base, base_nxt;
  logic [MAT_W-1:0]       snap;
  logic                   load;
  logic                   wd_nxt, ovr_nxt;
  logic                   we_q, we_nxt;
  logic [AWIDTH-1:0]      addr_q, addr_nxt;
  logic [MEM_WIDTH-1:0]   data_q, data_nxt;
  logic                   wd_q, ovr_q;
  logic [MAT_W-1:0]       mux_src;
  logic [ROW_W-1:0]       row_word;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, row/base sequencing and the overrun/done flags.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    base_nxt  = base;
    load      = 1'b0;
    wd_nxt    = 1'b0;
    ovr_nxt   = ovr_q;
    if (done_mat_mul && state != S_IDLE) ovr_nxt = 1'b1;
    case (state)
      S_IDLE: begin
        if (done_mat_mul) begin
          load      = 1'b1;
          base_nxt  = c_loc;
          row_nxt   = '0;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // we_c is always high here, so mem_ready alone marks acceptance.
        if (ram.mem_ready) begin
          if (row == LAST_ROW) begin
            state_nxt = S_FINISH;
            wd_nxt    = 1'b1;
          end else begin
            row_nxt = row + ROWB'(1);
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Row 0 must come straight from c_flat on the load edge.
  assign mux_src = load ? c_flat : snap;

  matmul_row_mux #(
    .DWIDTH (DWIDTH),
    .MAT    (MAT),
    .ROWB   (ROWB)
  ) u_row_mux (
    .mat  (mux_src),
    .row  (row_nxt),
    .word (row_word)
  );

  // Next values of the registered write port; address/data hold when idle.
  always_comb begin
    we_nxt   = (state_nxt == S_WRITE);
    addr_nxt = addr_q;
    data_nxt = data_q;
    if (we_nxt) begin
      addr_nxt = base_nxt + AWIDTH'(row_nxt);
      data_nxt = row_word;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row    <= '0;
      base   <= '0;
      snap   <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      wd_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      row    <= row_nxt;
      base   <= base_nxt;
      if (load) snap <= c_flat;
      we_q   <= we_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      wd_q   <= wd_nxt;
      ovr_q  <= ovr_nxt;
    end
  end

  assign ram.we_c    = we_q;
  assign ram.addr_c  = addr_q;
  assign ram.data_c  = data_q;
  assign busy        = (state != S_IDLE);
  assign writes_done = wd_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_matmul_output_writer.sv
// Bench for matmul_output_writer: table of jobs plus hand sequences for
// overrun, reset mid-transfer and done in the finish cycle.
module tb_matmul_output_writer;
  import matmul_pkg::*;

  typedef logic [3:0][3:0][15:0] mat_t;

  typedef struct {
    mat_t              m;
    logic [6:0]        loc;
    logic [7:0]        rdy;
    logic [3:0][63:0]  words;
    int                lat;
  } vec_t;

  typedef struct {
    logic [6:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         done_mat_mul = 1'b0;
  logic [255:0] c_flat = '0;
  logic [6:0]   c_loc = '0;
  logic         busy, writes_done, overrun;

  matmul_output_writer_if bus ();

  matmul_output_writer dut (
    .clk          (clk),
    .reset        (reset),
    .done_mat_mul (done_mat_mul),
    .c_flat       (c_flat),
    .c_loc        (c_loc),
    .ram          (bus),
    .busy         (busy),
    .writes_done  (writes_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  wr_t sb[$];
  int  n_vec = 0, n_err = 0;
  int  cyc = 0, wd_cnt = 0, wd_cyc = 0, n_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every presented write must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      if (writes_done) begin
        wd_cnt++;
        wd_cyc = cyc;
      end
      if (bus.we_c) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr %h data %h with nothing expected", bus.addr_c, bus.data_c);
        end else begin
          check("wr_addr", 64'(bus.addr_c), 64'(sb[0].addr));
          check("wr_data", bus.data_c, sb[0].data);
          if (bus.mem_ready) begin
            void'(sb.pop_front());
            n_acc++;
          end
        end
      end
    end
  end

  function automatic logic [255:0] flat(input mat_t m);
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        f[(i*4+j)*16 +: 16] = m[i][j];
    return f;
  endfunction

  function automatic logic [63:0] row_word(input mat_t m, input int i);
    return {m[i][3], m[i][2], m[i][1], m[i][0]};
  endfunction

  function automatic int model_lat(input logic [7:0] rdy);
    int rows = 0;
    int k = 0;
    while (rows < 4) begin
      if (k > 7 || rdy[k]) rows++;
      k++;
    end
    return k + 1;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = 16'($urandom);
    return m;
  endfunction

  task automatic check_reset_outs(input string tag);
    check({tag, "_we"},       64'(bus.we_c), 64'd0);
    check({tag, "_addr"},     64'(bus.addr_c), 64'd0);
    check({tag, "_data"},     bus.data_c, 64'd0);
    check({tag, "_busy"},     64'(busy), 64'd0);
    check({tag, "_wd"},       64'(writes_done), 64'd0);
    check({tag, "_overrun"},  64'(overrun), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      done_mat_mul  = 1'b0;
      bus.mem_ready = 1'($urandom);
    end
  endtask

  // One job: done in cycle T, mem_ready per pattern from T+1. dup_at/rst_at
  // are cycle offsets from T for a second done pulse or a reset (-1 = none).
  task automatic run_job(input vec_t v, input int dup_at, input mat_t alt, input int rst_at);
    int t0, w0;
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) sb.push_back('{7'(int'(v.loc) + r), v.words[r]});
    t0 = cyc;
    w0 = wd_cnt;
    done_mat_mul  = 1'b1;
    c_flat        = flat(v.m);
    c_loc         = v.loc;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      done_mat_mul  = 1'b0;
      c_flat        = {8{$urandom}};
      c_loc         = 7'($urandom);
      bus.mem_ready = (k > 7) ? 1'b1 : v.rdy[k];
      if (k + 1 == dup_at) begin
        done_mat_mul = 1'b1;
        c_flat       = flat(alt);
      end
      if (k + 1 == rst_at) begin
        reset = 1'b0;
        #1;
        check("async_we_drop", 64'(bus.we_c), 64'd0);
        check("async_busy_drop", 64'(busy), 64'd0);
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
      if (dup_at > 0 && k == dup_at) check("overrun_set", 64'(overrun), 64'd1);
      if (wd_cnt != w0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL job_timeout: no writes_done within 40 cycles of T=%0d", t0);
    end
    if (rst_at < 0) begin
      check("wd_latency", 64'(wd_cyc - t0), 64'(v.lat));
      check("wd_pulses", 64'(wd_cnt - w0), 64'd1);
      check("sb_drained", 64'(sb.size()), 64'd0);
    end
    if (done_mat_mul) begin
      @(posedge clk); #1;
    end
    done_mat_mul = 1'b0;
  endtask

  initial begin
    vec_t tbl[5];
    logic [15:0] ci[16];
    mat_t m1, alt;
    int acc0, wd0;

    ci = '{16'h62, 16'h5A, 16'h52, 16'h22,
           16'h4B, 16'h3F, 16'h33, 16'h1A,
           16'h3E, 16'h30, 16'h2C, 16'h13,
           16'h36, 16'h28, 16'h2E, 16'h0D};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m1[i][j] = ci[i*4+j];

    tbl[0].m = m1;  tbl[0].loc = 7'd0;  tbl[0].rdy = 8'hFF;  tbl[0].lat = 5;
    tbl[0].words[0] = 64'h0022_0052_005A_0062;
    tbl[0].words[1] = 64'h001A_0033_003F_004B;
    tbl[0].words[2] = 64'h0013_002C_0030_003E;
    tbl[0].words[3] = 64'h000D_002E_0028_0036;
    tbl[1] = tbl[0];
    tbl[1].rdy = 8'b1111_1001;
    tbl[1].lat = 7;
    for (int n = 2; n < 5; n++) begin
      tbl[n].m   = rand_mat();
      tbl[n].loc = (n == 2) ? 7'd126 : 7'($urandom);
      tbl[n].rdy = (n == 2) ? 8'hFF : 8'($urandom);
      tbl[n].lat = model_lat(tbl[n].rdy);
      for (int r = 0; r < 4; r++) tbl[n].words[r] = row_word(tbl[n].m, r);
    end
    alt = rand_mat();

    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("in_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("after_reset");

    // Table jobs issue back to back with 6-cycle spacing when ready is high.
    for (int n = 0; n < 5; n++) run_job(tbl[n], -1, alt, -1);
    check("table_writes", 64'(n_acc), 64'd20);
    check("table_wd_pulses", 64'(wd_cnt), 64'd5);
    check("table_no_overrun", 64'(overrun), 64'd0);

    // Second done during WRITE: ignored, flagged, first job's data only.
    wd0 = wd_cnt;
    run_job(tbl[0], 2, alt, -1);
    idle(8);
    check("overrun_sticky", 64'(overrun), 64'd1);
    check("overrun_no_second_job", 64'(wd_cnt - wd0), 64'd1);

    // Reset mid-transfer, then a complete job.
    run_job(tbl[2], -1, alt, 2);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outs("post_abort");
    acc0 = n_acc;
    run_job(tbl[3], -1, alt, -1);
    check("post_abort_rows", 64'(n_acc - acc0), 64'd4);
    check("post_abort_no_overrun", 64'(overrun), 64'd0);

    // Done in the FINISH cycle also counts as overrun.
    wd0 = wd_cnt;
    run_job(tbl[0], 5, alt, -1);
    idle(8);
    check("finish_overrun", 64'(overrun), 64'd1);
    check("finish_no_second_job", 64'(wd_cnt - wd0), 64'd1);
    check("final_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_output_writer.md
# matmul_output_writer

Drains the 16 results of the 4x4 fp16 systolic matrix multiply into the output matrix RAM (matrix C). It sits directly downstream of the systolic array. On the array's done pulse it snapshots all 16 result elements, then writes them row by row as four 64-bit words, at a programmable base address, through a ready-gated RAM write port. The array is free to start its next multiply the cycle after the snapshot.

## Interface

Parameters:
- `DWIDTH`, default 16: element width (fp16 bit pattern; the block never interprets it).
- `MAT`, default 4: matrix dimension; `MAT*DWIDTH` must equal `MEM_WIDTH`.
- `AWIDTH`, default 7: output RAM address width.
- `MEM_WIDTH`, default 64: output RAM word width.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `done_mat_mul`  in  1  one-cycle pulse from the array; the results are valid in the same cycle.
- `c_flat`  in  256  results, with element Cij at bits [(i*4+j)*16 +: 16].
- `c_loc`  in  AWIDTH  base address of row 0, sampled with `done_mat_mul`.
- `mem_ready`  in  1  RAM/arbiter accepts a write this cycle.
- `we_c`  out  1  write request.
- `addr_c`  out  AWIDTH  write address.
- `data_c`  out  64  write data.
- `busy`  out  1  snapshot held, writes pending.
- `writes_done`  out  1  one-cycle pulse after the last row is accepted.
- `overrun`  out  1  sticky error flag; cleared only by reset.

## Operation

State machine: IDLE, WRITE, FINISH.
- **IDLE**:
  - `we_c`=0.
  - On `done_mat_mul`: latch `c_flat` into the snapshot register, latch `c_loc`, set row=0, go to WRITE.
- **WRITE**:
  - `we_c`=1, `addr_c`=base+row (mod 2^AWIDTH, so it wraps).
  - `data_c` = row `row` of the snapshot, with column j at bits [16j+15:16j]. Column 0 is at the LSB, the same packing as the A/B RAMs.
  - A write is accepted when `we_c && mem_ready`. On acceptance, row increments. On acceptance of row 3, go to FINISH.
  - When `mem_ready`=0, hold `addr_c`, `data_c` and `we_c` stable. There is no timeout.
- **FINISH**: `writes_done`=1 for exactly one cycle, then go to IDLE.
- `busy` = (state != IDLE).

Boundary rules:
- **`done_mat_mul` while busy**: the pulse is ignored, the snapshot is untouched, and `overrun` is set.
- **`done_mat_mul` in the FINISH cycle**: also counts as overrun. A new job is accepted only in IDLE.
- **Reset mid-transfer**: the transfer is abandoned immediately and `we_c` drops asynchronously. No partial-row recovery.
- **Reset values**:
  - state IDLE, row 0
  - `we_c`, `busy`, `writes_done`, `overrun` all 0
  - `addr_c` 0, `data_c` 0; the snapshot register clears to 0.
- **Idle outputs**: `data_c`/`addr_c` hold their last driven values while IDLE. They are don't-care for the RAM since `we_c`=0.

## Timing

- Snapshot and state change at the `done_mat_mul` edge (cycle T).
- With `mem_ready` constantly high:
  - rows 0..3 are written in cycles T+1..T+4;
  - `writes_done` is high in cycle T+5;
  - IDLE, ready for a new job, from T+6.
- Each low `mem_ready` cycle during WRITE adds one cycle to the total latency.
- Outputs are registered: `we_c`, `addr_c` and `data_c` change only on clock edges. The exception is the asynchronous reset.
- Minimum spacing between accepted jobs is 6 cycles.

## Structure

- Shared package `matmul_pkg`:
  - constants `DWIDTH`, `MAT`, `AWIDTH`, `MEM_WIDTH`;
  - state enum (`S_IDLE`, `S_WRITE`, `S_FINISH`);
  - typedef `fp16_t` (16-bit bit-pattern type).
- One natural sub-module, `matmul_row_mux`: selects and packs row `row` of the snapshot into a 64-bit word. Purely combinational; its output is registered in the parent.
- The instantiation replaces the C-side output logic in `matrix_multiplication`. `we_c`/`addr_c`/`data_c` drive the `matrix_C` RAM port.

## Test plan

1. **Integer product, `c_loc`=0, ready high**:
   - Stimulus: C = [[0x62,0x5A,0x52,0x22],[0x4B,0x3F,0x33,0x1A],[0x3E,0x30,0x2C,0x13],[0x36,0x28,0x2E,0x0D]].
   - Required: writes at T+1..T+4 to addr 0..3.
     - addr 0: 64'h0022_0052_005A_0062
     - addr 1: 64'h001A_0033_003F_004B
     - addr 2: 64'h0013_002C_0030_003E
     - addr 3: 64'h000D_002E_0028_0036
   - `writes_done` at T+5.
2. **Back-pressure**:
   - Stimulus: as test 1, with `mem_ready` low at T+2 and T+3.
   - Required: addr 1 data held for 3 cycles; `writes_done` at T+7.
3. **Address wrap**:
   - Stimulus: `c_loc`=126.
   - Required: addresses 126, 127, 0, 1.
4. **Overrun**:
   - Stimulus: second `done_mat_mul` at T+2 with different data.
   - Required: `overrun`=1 from T+3 and stays set; the four writes carry the first job's data only; no second job follows.
5. **Reset mid-transfer**:
   - Stimulus: `reset` low during T+2.
   - Required: `we_c` drops immediately. After release: all outputs at reset values, state IDLE, and the next `done_mat_mul` performs a full 4-row write.
6. **Back-to-back jobs**:
   - Stimulus: second done at T+6.
   - Required: accepted, 8 total writes, 2 `writes_done` pulses, `overrun`=0.
